// File: rtl/repeat_run_detector.sv
// Repeat-run detector: tracks runs of equal symbols and pulses at run lengths 2, 3 and thr.
// Define REPEAT_STATS_EN to build the pair/triple event counters and the max_run tracker.
module repeat_run_detector #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   input  logic              mode,
   input  logic [CNT_W-1:0]  thr,
   output logic [CNT_W-1:0]  run_len,
   output logic              pair_p,
   output logic              triple_p,
   output logic              thr_p,
   output logic [15:0]       pair_cnt,
   output logic [15:0]       triple_cnt,
   output logic [CNT_W-1:0]  max_run
);

   // state | meaning
   // EMPTY | no previous symbol held; next valid sample starts a run at 1
   // TRACK | prev holds the last symbol; run_len counts its repeats
   typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LEN_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] LEN_THR = CNT_W'(3);

   state_t             state, state_n;
   logic [DATA_W-1:0]  prev, prev_n;
   logic [CNT_W-1:0]   len_n;
   logic [CNT_W-1:0]   grown;
   logic               pair_n, triple_n, thr_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         prev     <= '0;
         run_len  <= '0;
         pair_p   <= 1'b0;
         triple_p <= 1'b0;
         thr_p    <= 1'b0;
      end else begin
         state    <= state_n;
         prev     <= prev_n;
         run_len  <= len_n;
         pair_p   <= pair_n;
         triple_p <= triple_n;
         thr_p    <= thr_n;
      end
   end

   always_comb begin
      state_n  = state;
      prev_n   = prev;
      len_n    = run_len;
      pair_n   = 1'b0;
      triple_n = 1'b0;
      thr_n    = 1'b0;
      grown    = run_len + LEN_ONE;

      if (clear) begin
         state_n = EMPTY;
         len_n   = '0;
      end

      if (in_valid) begin
         // a sample arriving with clear is the first sample of a fresh run
         if (clear || state == EMPTY) begin
            state_n = TRACK;
            prev_n  = in_data;
            len_n   = LEN_ONE;
         end else if (in_data == prev) begin
            // saturated runs hold silently so no trigger can repeat
            if (run_len != LEN_MAX) begin
               pair_n   = (grown == LEN_TWO);
               triple_n = (grown == LEN_THR);
               thr_n    = (thr >= LEN_TWO) && (grown == thr);
               len_n    = (mode && thr_n) ? '0 : grown;
            end
         end else begin
            prev_n = in_data;
            len_n  = LEN_ONE;
         end
      end
   end

`ifdef REPEAT_STATS_EN
   logic [CNT_W-1:0] seen_len;
   logic [CNT_W-1:0] max_n;

   // in non-overlapping mode the stored length drops to 0, but the run did reach thr
   always_comb begin
      seen_len = thr_n ? thr : len_n;
      max_n    = clear ? '0 : max_run;
      if (in_valid && seen_len > max_n)
         max_n = seen_len;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_cnt   <= '0;
         triple_cnt <= '0;
         max_run    <= '0;
      end else begin
         max_run <= max_n;
         if (pair_n && pair_cnt != 16'hFFFF)
            pair_cnt <= pair_cnt + 16'd1;
         if (triple_n && triple_cnt != 16'hFFFF)
            triple_cnt <= triple_cnt + 16'd1;
      end
   end
`else
   assign pair_cnt   = '0;
   assign triple_cnt = '0;
   assign max_run    = '0;
`endif

endmodule

// File: tb/tb_repeat_run_detector.sv
// Directed bench for repeat_run_detector; stats expectations follow REPEAT_STATS_EN.
module tb_repeat_run_detector;

`ifdef REPEAT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       clear = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] thr = 4'd4;
   logic [3:0] run_len;
   logic       pair_p, triple_p, thr_p;
   logic [15:0] pair_cnt, triple_cnt;
   logic [3:0] max_run;

   int vectors = 0;
   int miscompares = 0;

   repeat_run_detector #(.DATA_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .clear(clear), .mode(mode), .thr(thr), .run_len(run_len),
      .pair_p(pair_p), .triple_p(triple_p), .thr_p(thr_p),
      .pair_cnt(pair_cnt), .triple_cnt(triple_cnt), .max_run(max_run)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // drive one cycle, then check registered outputs 1ns after the edge
   task automatic step(input logic v, input logic [7:0] d, input logic c,
                       input int e_len, input logic e_pair, input logic e_tri,
                       input logic e_thr, input string tag);
      in_valid = v;
      in_data  = d;
      clear    = c;
      @(posedge clk);
      #1;
      chk({tag, ".run_len"}, 32'(run_len), 32'(e_len));
      chk({tag, ".pair_p"}, 32'(pair_p), 32'(e_pair));
      chk({tag, ".triple_p"}, 32'(triple_p), 32'(e_tri));
      chk({tag, ".thr_p"}, 32'(thr_p), 32'(e_thr));
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic stats(input int e_pc, input int e_tc, input int e_max, input string tag);
      chk({tag, ".pair_cnt"}, 32'(pair_cnt), STATS ? 32'(e_pc) : 32'd0);
      chk({tag, ".triple_cnt"}, 32'(triple_cnt), STATS ? 32'(e_tc) : 32'd0);
      chk({tag, ".max_run"}, 32'(max_run), STATS ? 32'(e_max) : 32'd0);
   endtask

   initial begin
      #22 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset.run_len", 32'(run_len), 32'd0);
      chk("reset.pulses", {29'd0, pair_p, triple_p, thr_p}, 32'd0);
      stats(0, 0, 0, "reset");

      // overlapping, thr=4: pulses on samples 2,3,4
      mode = 1'b0; thr = 4'd4;
      step(1, 8'd5, 0, 1, 0, 0, 0, "ov.s1");
      step(1, 8'd5, 0, 2, 1, 0, 0, "ov.s2");
      step(1, 8'd5, 0, 3, 0, 1, 0, "ov.s3");
      step(1, 8'd5, 0, 4, 0, 0, 1, "ov.s4");
      step(1, 8'd7, 0, 1, 0, 0, 0, "ov.s7");
      step(0, 8'd7, 0, 1, 0, 0, 0, "ov.idle");
      stats(1, 1, 4, "ov");

      // non-overlapping, thr=2
      step(0, 8'd0, 1, 0, 0, 0, 0, "nov.clear");
      stats(1, 1, 0, "nov.clear");
      mode = 1'b1; thr = 4'd2;
      step(1, 8'd5, 0, 1, 0, 0, 0, "nov.s1");
      step(1, 8'd5, 0, 0, 1, 0, 1, "nov.s2");
      step(1, 8'd5, 0, 1, 0, 0, 0, "nov.s3");
      step(1, 8'd5, 0, 0, 1, 0, 1, "nov.s4");
      step(1, 8'd5, 0, 1, 0, 0, 0, "nov.s5");
      stats(3, 1, 2, "nov");

      // saturation with thr at the top value; first sample arrives with clear
      mode = 1'b0; thr = 4'd15;
      for (int i = 1; i <= 20; i++)
         step(1, 8'd3, i == 1, (i < 15) ? i : 15, i == 2, i == 3, i == 15, "sat");
      stats(4, 2, 15, "sat");

      // clear together with a same-symbol sample restarts at 1
      thr = 4'd4;
      step(0, 8'd0, 1, 0, 0, 0, 0, "clr.clear");
      step(1, 8'd8, 0, 1, 0, 0, 0, "clr.s1");
      step(1, 8'd8, 0, 2, 1, 0, 0, "clr.s2");
      step(1, 8'd8, 0, 3, 0, 1, 0, "clr.s3");
      stats(5, 3, 3, "clr.run");
      step(1, 8'd8, 1, 1, 0, 0, 0, "clr.both");
      stats(5, 3, 1, "clr.both");

      // async reset between two equal samples
      step(1, 8'd6, 0, 1, 0, 0, 0, "rst.s1");
      #2 rst = 1'b1;
      #1;
      chk("rst.async_run_len", 32'(run_len), 32'd0);
      stats(0, 0, 0, "rst.async");
      #1 rst = 1'b0;
      step(1, 8'd6, 0, 1, 0, 0, 0, "rst.s2");

      // valid gaps hold state
      step(1, 8'd4, 0, 1, 0, 0, 0, "gap.s1");
      step(0, 8'd4, 0, 1, 0, 0, 0, "gap.g1");
      step(0, 8'd9, 0, 1, 0, 0, 0, "gap.g2");
      step(0, 8'd4, 0, 1, 0, 0, 0, "gap.g3");
      step(1, 8'd4, 0, 2, 1, 0, 0, "gap.s2");

      // thr below 2 never fires
      thr = 4'd1;
      step(1, 8'd4, 0, 3, 0, 1, 0, "thr1.s3");
      thr = 4'd0;
      step(1, 8'd4, 0, 4, 0, 0, 0, "thr0.s4");
      stats(1, 1, 4, "end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
